// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external 32-bit combinational ALU between the main
// datapath port (0) and the auxiliary/branch-compare port (1), with per-port responses.
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,
    output logic             rsp0_ovf,
    output logic             rsp0_ill,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,
    output logic             rsp1_ovf,
    output logic             rsp1_ill,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zout,
    input  logic             alu_overflow,
    output logic             busy
);

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b101;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_reg, state_next;
    logic             prio_reg;
    logic             owner_reg;
    logic [WIDTH-1:0] alu_a_reg, alu_b_reg;
    logic [2:0]       alu_control_reg;
    logic [WIDTH-1:0] rsp_result_reg [2];
    logic [1:0]       rsp_zero_reg, rsp_ovf_reg, rsp_ill_reg;

    logic [1:0]       req_valid, rsp_ready_vec, rsp_valid_vec;
    logic [1:0]       grant, accept;
    logic             grant_idx, can_grant;
    logic [WIDTH-1:0] req_a [2];
    logic [WIDTH-1:0] req_b [2];
    logic [2:0]       req_op [2];
    logic [WIDTH-1:0] cap_result;
    logic             cap_zero, cap_ovf, cap_ill;

    assign req_valid     = {req1_valid, req0_valid};
    assign rsp_ready_vec = {rsp1_ready, rsp0_ready};
    assign req_a[0]  = req0_a;
    assign req_a[1]  = req1_a;
    assign req_b[0]  = req0_b;
    assign req_b[1]  = req1_b;
    assign req_op[0] = req0_op;
    assign req_op[1] = req1_op;

    // Arbitration: a lone requester wins; on contention prio picks the winner.
    always_comb begin
        grant_idx = (req_valid == 2'b11) ? prio_reg : req_valid[1];
        can_grant = (state_reg == IDLE) && !reset && (|req_valid);
        grant     = can_grant ? (2'b01 << grant_idx) : 2'b00;
        accept    = grant & req_valid;
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (|accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready_vec[owner_reg]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: only the owner's response channel is ever offered.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rsp_valid
            assign rsp_valid_vec[gi] = (state_reg == RESP) && (owner_reg == 1'(gi));
        end
    endgenerate

    assign busy       = (state_reg != IDLE);
    assign rsp0_valid = rsp_valid_vec[0];
    assign rsp1_valid = rsp_valid_vec[1];

    // Operand/owner capture and round-robin pointer update.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_reg        <= 1'b0;
            owner_reg       <= 1'b0;
            alu_a_reg       <= '0;
            alu_b_reg       <= '0;
            alu_control_reg <= 3'b000;
        end else begin
            if (|accept) begin
                owner_reg       <= grant_idx;
                alu_a_reg       <= req_a[grant_idx];
                alu_b_reg       <= req_b[grant_idx];
                alu_control_reg <= req_op[grant_idx];
            end
            if ((state_reg == RESP) && rsp_ready_vec[owner_reg]) begin
                prio_reg <= ~owner_reg;
            end
        end
    end

    // The ALU's overflow is stale outside add/sub, and its output is meaningless for 101.
    always_comb begin
        cap_result = alu_out;
        cap_zero   = alu_zout;
        cap_ovf    = 1'b0;
        cap_ill    = 1'b0;
        if (alu_control_reg == OP_ILL) begin
            cap_result = '0;
            cap_zero   = 1'b1;
            cap_ill    = 1'b1;
        end else if ((alu_control_reg == OP_ADD) || (alu_control_reg == OP_SUB)) begin
            cap_ovf = alu_overflow;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                rsp_result_reg[i] <= '0;
            end
            rsp_zero_reg <= 2'b00;
            rsp_ovf_reg  <= 2'b00;
            rsp_ill_reg  <= 2'b00;
        end else if (state_reg == EXEC) begin
            rsp_result_reg[owner_reg] <= cap_result;
            rsp_zero_reg[owner_reg]   <= cap_zero;
            rsp_ovf_reg[owner_reg]    <= cap_ovf;
            rsp_ill_reg[owner_reg]    <= cap_ill;
        end
    end

    assign alu_a       = alu_a_reg;
    assign alu_b       = alu_b_reg;
    assign alu_control = alu_control_reg;
    assign rsp0_result = rsp_result_reg[0];
    assign rsp1_result = rsp_result_reg[1];
    assign rsp0_zero   = rsp_zero_reg[0];
    assign rsp1_zero   = rsp_zero_reg[1];
    assign rsp0_ovf    = rsp_ovf_reg[0];
    assign rsp1_ovf    = rsp_ovf_reg[1];
    assign rsp0_ill    = rsp_ill_reg[0];
    assign rsp1_ill    = rsp_ill_reg[1];

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus randomized traffic, checked
// every cycle against a transaction-level model; the external ALU is modelled here.
module tb_alu_share_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_result, rsp1_result;
    logic        rsp0_zero, rsp1_zero, rsp0_ovf, rsp1_ovf, rsp0_ill, rsp1_ill;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [2:0]  alu_control;
    logic        alu_zout, alu_overflow, busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_txn    = 0;
    int          grant_log[$];

    // Garbage the external ALU shows where its outputs are not meaningful.
    logic [31:0] junk_out;
    logic        junk_ovf;
    bit          rand_junk;

    // Reference model state (transaction level)
    bit          m_busy, m_offered, m_owner, m_prio, m_just_reset;
    logic [31:0] m_alu_a, m_alu_b;
    logic [2:0]  m_alu_op;
    logic [31:0] m_res [2];
    bit          m_zero [2];
    bit          m_ovf [2];
    bit          m_ill [2];

    alu_share_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_zero(rsp0_zero), .rsp0_ovf(rsp0_ovf), .rsp0_ill(rsp0_ill),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_zero(rsp1_zero), .rsp1_ovf(rsp1_ovf), .rsp1_ill(rsp1_ill),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_out(alu_out), .alu_zout(alu_zout), .alu_overflow(alu_overflow),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        case (op)
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b011:  return a ^ b;
            3'b100:  return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    // Signed overflow: the exact result falls outside the 32-bit signed range.
    function automatic bit ref_ovf(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] op);
        longint sa, sb, r;
        sa = $signed(a);
        sb = $signed(b);
        r  = (op == 3'b110) ? (sa - sb) : (sa + sb);
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    assign alu_out      = (alu_control == 3'b101) ? junk_out : ref_alu(alu_a, alu_b, alu_control);
    assign alu_overflow = (alu_control == 3'b010 || alu_control == 3'b110) ?
                          ref_ovf(alu_a, alu_b, alu_control) : junk_ovf;
    assign alu_zout     = (alu_out == 32'd0);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_busy = 0; m_offered = 0; m_owner = 0; m_prio = 0;
        m_alu_a = '0; m_alu_b = '0; m_alu_op = 3'b000;
        for (int i = 0; i < 2; i++) begin
            m_res[i] = '0; m_zero[i] = 0; m_ovf[i] = 0; m_ill[i] = 0;
        end
    endtask

    // One clock: check outputs against the model, advance the model across the edge.
    task automatic cycle();
        logic [1:0] v;
        bit have_w, w, done;
        junk_out = rand_junk ? ($urandom | 32'd1) : 32'hDEAD_BEEF;
        junk_ovf = rand_junk ? 1'($urandom) : 1'b1;
        #1;
        v      = {req1_valid, req0_valid};
        have_w = !m_busy && !reset && (v != 2'b00);
        w      = (v == 2'b11) ? m_prio : v[1];
        if (req0_valid && req0_ready) grant_log.push_back(0);
        if (req1_valid && req1_ready) grant_log.push_back(1);
        check_eq("req0_ready", req0_ready, have_w && !w);
        check_eq("req1_ready", req1_ready, have_w && w);
        check_eq("busy", busy, m_busy);
        check_eq("rsp0_valid", rsp0_valid, m_busy && m_offered && !m_owner);
        check_eq("rsp1_valid", rsp1_valid, m_busy && m_offered && m_owner);
        check_eq("alu_a", alu_a, m_alu_a);
        check_eq("alu_b", alu_b, m_alu_b);
        check_eq("alu_control", alu_control, m_alu_op);
        if ((m_busy && m_offered && !m_owner) || m_just_reset) begin
            check_eq("rsp0_result", rsp0_result, m_res[0]);
            check_eq("rsp0_zero", rsp0_zero, m_zero[0]);
            check_eq("rsp0_ovf", rsp0_ovf, m_ovf[0]);
            check_eq("rsp0_ill", rsp0_ill, m_ill[0]);
        end
        if ((m_busy && m_offered && m_owner) || m_just_reset) begin
            check_eq("rsp1_result", rsp1_result, m_res[1]);
            check_eq("rsp1_zero", rsp1_zero, m_zero[1]);
            check_eq("rsp1_ovf", rsp1_ovf, m_ovf[1]);
            check_eq("rsp1_ill", rsp1_ill, m_ill[1]);
        end
        if (reset) begin
            model_clear();
            m_just_reset = 1;
        end else begin
            m_just_reset = 0;
            if (!m_busy) begin
                if (have_w) begin
                    m_busy = 1; m_offered = 0; m_owner = w;
                    m_alu_a  = w ? req1_a : req0_a;
                    m_alu_b  = w ? req1_b : req0_b;
                    m_alu_op = w ? req1_op : req0_op;
                end
            end else if (!m_offered) begin
                m_offered = 1;
                if (m_alu_op == 3'b101) begin
                    m_res[m_owner] = '0; m_zero[m_owner] = 1; m_ovf[m_owner] = 0; m_ill[m_owner] = 1;
                end else begin
                    m_res[m_owner]  = ref_alu(m_alu_a, m_alu_b, m_alu_op);
                    m_zero[m_owner] = (m_res[m_owner] == 32'd0);
                    m_ovf[m_owner]  = (m_alu_op == 3'b010 || m_alu_op == 3'b110) ?
                                      ref_ovf(m_alu_a, m_alu_b, m_alu_op) : 1'b0;
                    m_ill[m_owner]  = 0;
                end
            end else begin
                done = m_owner ? rsp1_ready : rsp0_ready;
                if (done) begin
                    n_txn++;
                    $display("txn %0d: req%0d op=%b a=%h b=%h result=%h zero=%b ovf=%b ill=%b",
                             n_txn, m_owner, m_alu_op, m_alu_a, m_alu_b, m_res[m_owner],
                             m_zero[m_owner], m_ovf[m_owner], m_ill[m_owner]);
                    m_busy = 0;
                    m_prio = ~m_owner;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
    endtask

    task automatic set_req(input bit n, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op);
        if (n) begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
        else   begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
    endtask

    task automatic do_reset();
        reset = 1; cycle(); reset = 0;
    endtask

    // Issue one request from an idle arbiter and stop with its response on offer.
    task automatic run_op(input bit n, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op);
        set_req(n, a, b, op);
        cycle();
        if (n) req1_valid = 0; else req0_valid = 0;
        cycle();
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rand_junk = 0;
        reset = 1;
        idle_inputs();
        req0_a = '0; req0_b = '0; req0_op = '0; req1_a = '0; req1_b = '0; req1_op = '0;
        junk_out = 32'hDEAD_BEEF; junk_ovf = 1;
        model_clear();
        m_just_reset = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        do_reset();

        // Overflowing add on port 0
        run_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 3'b010);
        check_eq("add_ovf_valid", rsp0_valid, 1);
        check_eq("add_ovf_result", rsp0_result, 32'h8000_0000);
        check_eq("add_ovf_ovf", rsp0_ovf, 1);
        check_eq("add_ovf_zero", rsp0_zero, 0);
        cycle();

        // Simultaneous requests right after reset: port 0 first, then port 1
        do_reset();
        set_req(0, 32'h0000_F0F0, 32'h0000_0FF0, 3'b000);
        set_req(1, 32'd5, 32'd5, 3'b110);
        cycle();
        req0_valid = 0;
        cycle();
        check_eq("simul_rsp0_result", rsp0_result, 32'h0000_00F0);
        check_eq("simul_rsp1_idle", rsp1_valid, 0);
        cycle();
        cycle();
        req1_valid = 0;
        cycle();
        check_eq("simul_rsp1_valid", rsp1_valid, 1);
        check_eq("simul_rsp1_result", rsp1_result, 32'd0);
        check_eq("simul_rsp1_zero", rsp1_zero, 1);
        check_eq("simul_rsp1_ovf", rsp1_ovf, 0);
        cycle();

        // Contested back-to-back requests alternate grants
        do_reset();
        grant_log.delete();
        set_req(0, 32'd11, 32'd3, 3'b011);
        set_req(1, 32'd7, 32'd9, 3'b111);
        repeat (12) cycle();
        idle_inputs();
        check_eq("alt_count", grant_log.size(), 4);
        if (grant_log.size() >= 4) begin
            check_eq("alt_grant0", grant_log[0], 0);
            check_eq("alt_grant1", grant_log[1], 1);
            check_eq("alt_grant2", grant_log[2], 0);
            check_eq("alt_grant3", grant_log[3], 1);
        end
        cycle();

        // Set on less than, signed
        run_op(1, 32'hFFFF_FFFF, 32'h0000_0001, 3'b111);
        check_eq("slt_lt_result", rsp1_result, 32'd1);
        cycle();
        run_op(1, 32'h0000_0001, 32'hFFFF_FFFF, 3'b111);
        check_eq("slt_ge_result", rsp1_result, 32'd0);
        check_eq("slt_ge_zero", rsp1_zero, 1);
        cycle();

        // Stale overflow masking and illegal op (ALU shows overflow=1 on other ops)
        run_op(0, 32'h8000_0000, 32'h0000_0001, 3'b110);
        check_eq("sub_ovf_ovf", rsp0_ovf, 1);
        cycle();
        run_op(0, 32'd0, 32'd0, 3'b001);
        check_eq("or_mask_ovf", rsp0_ovf, 0);
        check_eq("or_mask_zero", rsp0_zero, 1);
        cycle();
        run_op(0, 32'h1234_5678, 32'h0000_0001, 3'b101);
        check_eq("ill_flag", rsp0_ill, 1);
        check_eq("ill_result", rsp0_result, 32'd0);
        cycle();

        // Response backpressure with port 1 waiting
        rsp0_ready = 0;
        run_op(0, 32'd3, 32'd4, 3'b010);
        set_req(1, 32'd100, 32'd1, 3'b110);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_eq("bp_rsp0_valid", rsp0_valid, 1);
            check_eq("bp_rsp0_result", rsp0_result, 32'd7);
            check_eq("bp_rsp0_ovf", rsp0_ovf, 0);
        end
        rsp0_ready = 1;
        cycle();
        cycle();
        req1_valid = 0;
        cycle();
        check_eq("bp_rsp1_result", rsp1_result, 32'd99);
        cycle();

        // Reset while an op is in EXEC
        set_req(0, 32'd1, 32'd2, 3'b010);
        cycle();
        req0_valid = 0;
        reset = 1;
        cycle();
        reset = 0;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rsp0_valid", rsp0_valid, 0);
        check_eq("rst_rsp1_valid", rsp1_valid, 0);
        check_eq("rst_alu_control", alu_control, 3'b000);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("rst_no_rsp", rsp0_valid, 0);
        end
        run_op(0, 32'd10, 32'd20, 3'b010);
        check_eq("rst_after_result", rsp0_result, 32'd30);
        cycle();

        // Randomized traffic
        rand_junk = 1;
        for (int c = 0; c < 1500; c++) begin
            reset      = ($urandom_range(0, 199) == 0);
            req0_valid = ($urandom_range(0, 9) < 7);
            req1_valid = ($urandom_range(0, 9) < 7);
            req0_a = rand_operand(); req0_b = rand_operand(); req0_op = 3'($urandom_range(0, 7));
            req1_a = rand_operand(); req1_b = rand_operand(); req1_op = 3'($urandom_range(0, 7));
            rsp0_ready = ($urandom_range(0, 9) < 6);
            rsp1_ready = ($urandom_range(0, 9) < 6);
            cycle();
        end
        reset = 0;
        idle_inputs();
        repeat (4) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

- Shares the single 32-bit combinational ALU between two requesters: requester 0 is the main datapath port, requester 1 is the auxiliary/branch-compare port.
- Each request is accepted through a valid/ready handshake, arbitrated round-robin, and its operands and op are registered onto the ALU inputs.
- The result, zero and overflow flags are captured after one settle cycle and returned over a per-requester valid/ready response channel.

## Interface
Parameters:
- WIDTH, 32, operand/result width; fixed to the ALU width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- req0_valid, req1_valid  in  1  request present.
- req0_ready, req1_ready  out  1  request accepted this cycle.
- req0_a/req0_b, req1_a/req1_b  in  32  operands.
- req0_op, req1_op  in  3  ALU control code: 010 add, 110 sub, 111 slt, 000 and, 001 or, 011 xor, 100 nor.
- rsp0_valid, rsp1_valid  out  1  response present.
- rsp0_ready, rsp1_ready  in  1  response consumed.
- rsp0_result, rsp1_result  out  32  registered ALU result.
- rsp0_zero, rsp1_zero  out  1  result == 0.
- rsp0_ovf, rsp1_ovf  out  1  signed overflow; add/sub only.
- rsp0_ill, rsp1_ill  out  1  illegal op (101).
- alu_a, alu_b  out  32  registered ALU operands.
- alu_control  out  3  registered ALU op.
- alu_out  in  32  ALU result.
- alu_zout  in  1  ALU zero flag.
- alu_overflow  in  1  ALU overflow flag.
- busy  out  1  state != IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE, arbitration:
  - One valid requester: it is granted.
  - Both valid: the requester selected by prio is granted.
  - prio resets to 0.
- IDLE, accept: reqN_ready = grantN, combinational, IDLE only, and forced 0 while reset is high. Accept = valid & ready.
- On accept:
  - Latch a, b and op into alu_a, alu_b and alu_control.
  - Latch owner = N.
  - Go to EXEC.
- EXEC: capture the response registers for owner, then go to RESP.
  - result = alu_out and zero = alu_zout.
  - ovf = alu_overflow only if op is 010 or 110, else 0. This masks the ALU's stale overflow on other ops.
  - If op == 101: result = 0, zero = 1, ovf = 0, ill = 1, and alu_out is ignored.
- RESP: rsp[owner]_valid = 1. The other rsp_valid stays 0.
  - Result and flags are held stable while valid and not ready.
  - On rsp[owner]_ready: go to IDLE, set prio = ~owner, and clear rsp_valid.
- No request is accepted in EXEC or RESP; both req_ready are 0.
- A requester's req_valid may stay high through its own busy period; it is re-arbitrated in IDLE like any other request.
- Reset at any state:
  - Next state is IDLE and any in-flight op is discarded; no response is issued.
  - Outputs clear: alu_a = 0, alu_b = 0, alu_control = 000, all rsp_valid/result/zero/ovf/ill = 0, prio = 0, busy = 0.

## Timing
- Request accepted at edge T.
- alu_* are valid after T; the ALU settles during cycle T..T+1.
- The response is registered at edge T+1, so rsp_valid is high from T+1: latency 1 cycle after acceptance.
- The response handshake completes at the first edge T+1+k where rsp_ready = 1.
- IDLE is re-entered after that edge; the earliest next accept is the following edge.
- Peak throughput: 1 op per 3 cycles.
- No combinational path exists from any rsp_ready to any req_ready except through the registered state.
- A request and its response for the same requester never overlap.
- alu_a, alu_b and alu_control hold their value from acceptance until the next acceptance.

## Test plan
- Overflow add: after reset, req0 add 0x7FFFFFFF + 0x00000001, rsp0_ready = 1.
  - req0_ready at T; rsp0_valid at T+1.
  - result 0x80000000, ovf = 1, zero = 0.
- Simultaneous requests: req0 and req1 valid on the same cycle after reset; req0 is and 0xF0F0 & 0x0FF0, req1 is sub 5 − 5.
  - req0 is served first: result 0x000000F0.
  - req1 is accepted on the first IDLE cycle after rsp0 completes: result 0, zero = 1, ovf = 0.
  - Across 4 back-to-back contested requests, grants alternate 0,1,0,1.
- Set on less than: req1 slt 0xFFFFFFFF vs 0x00000001 gives result 1. Swapped operands give result 0, zero = 1.
- Stale-flag masking and illegal op:
  - Sub 0x80000000 − 1 gives ovf = 1.
  - Next op or 0 | 0 gives ovf = 0 and zero = 1.
  - Op 101 gives ill = 1, result 0.
- Backpressure: hold rsp0_ready = 0 for 5 cycles with req1_valid high.
  - rsp0 result and flags stay constant and req1_ready stays 0.
  - Raise rsp0_ready: req1 is accepted 1 cycle after the rsp0 completion edge.
- Reset mid-operation: assert reset in EXEC.
  - Next cycle: busy = 0, all rsp_valid = 0, alu_control = 000.
  - No response for the discarded op appears afterwards.
  - The next request completes normally.
